// File: rtl/ssd_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_pkg
// Description : Shared definitions for the seven-segment scan driver: scan
//               phase enumeration, active-low segment codes {g,f,e,d,c,b,a},
//               anode idle pattern and the leading-zero helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_LIT   = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // True when digit idx (>0) and every more-significant nibble are zero,
    // i.e. the digit is a leading zero. Digit 0 is never a leading zero.
    function automatic logic lz_zero(input logic [15:0] v, input logic [1:0] idx);
        logic [15:0] hi;
        hi = v >> {idx, 2'b00};
        return (idx != 2'd0) && (hi == 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_hex_decoder
// Description : Combinational hex nibble to active-low seven-segment code.
// Ports       : nib [3:0] in  - hex value 0..F
//               seg [6:0] out - cathodes {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_decoder
    import ssd_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan
// Description : 4-digit multiplexed seven-segment driver with per-slot
//               blanking gap and optional leading-zero suppression.
// Ports       : ssd_clk        in   clock
//               ssd_rst_n      in   asynchronous active-low reset
//               ssd_en         in   display enable (0 = dark, scan restarts)
//               ssd_load       in   strobe: capture ssd_val/ssd_dp to shadow
//               ssd_val [15:0] in   four hex nibbles, digit3 = [15:12]
//               ssd_dp  [3:0]  in   decimal point per digit, 1 = lit
//               ssd_an  [3:0]  out  anodes, active-low, one-cold or all high
//               ssd_seg [6:0]  out  cathodes {g,f,e,d,c,b,a}, active-low
//               ssd_dp_n       out  decimal point cathode, active-low
//               ssd_digit[1:0] out  index of the current slot
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan
    import ssd_scan_pkg::*;
#(
    parameter int PRESCALE    = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        ssd_clk,
    input  logic        ssd_rst_n,
    input  logic        ssd_en,
    input  logic        ssd_load,
    input  logic [15:0] ssd_val,
    input  logic [3:0]  ssd_dp,
    output logic [3:0]  ssd_an,
    output logic [6:0]  ssd_seg,
    output logic        ssd_dp_n,
    output logic [1:0]  ssd_digit
);

    localparam int            CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] C_LAST     = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] C_BLANK    = CW'(BLANK_CYC);
    localparam logic [CW-1:0] C_BLANK_M1 = CW'(BLANK_CYC - 1);

    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;
    logic [3:0]    r_act_nib;
    logic          r_act_dp;
    logic          r_act_sup;
    scan_state_t   r_state;
    scan_state_t   w_state_nxt;

    logic          w_wrap;
    logic          w_cap;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_digit_nxt;
    logic [15:0]   w_src_val;
    logic [3:0]    w_src_dp;
    logic [15:0]   w_src_shift;
    logic [6:0]    w_seg_dec;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dpn_nxt;

    // Slot counter arithmetic; capture happens on the edge where cnt becomes
    // BLANK_CYC, which can never coincide with a wrap.
    always_comb begin
        w_wrap      = (r_cnt == C_LAST);
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
        w_digit_nxt = w_wrap ? r_digit + 2'd1 : r_digit;
        w_cap       = (r_cnt == C_BLANK_M1);
    end

    // A load coinciding with the capture edge is shown immediately.
    always_comb begin
        w_src_val   = ssd_load ? ssd_val : r_shadow_val;
        w_src_dp    = ssd_load ? ssd_dp  : r_shadow_dp;
        w_src_shift = w_src_val >> {r_digit, 2'b00};
    end

    ssd_hex_decoder u_dec (
        .nib (r_act_nib),
        .seg (w_seg_dec)
    );

    // Scan phase FSM: the registered state tracks which phase the current
    // cnt value lies in, so output registers lag cnt by one cycle.
    always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
        if (!ssd_rst_n) r_state <= ST_BLANK;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_BLANK;
        w_an_nxt    = AN_OFF;
        w_seg_nxt   = SEG_BLANK;
        w_dpn_nxt   = 1'b1;
        if (ssd_en && (w_cnt_nxt >= C_BLANK)) w_state_nxt = ST_LIT;
        // A suppressed digit without its decimal point keeps the anode off.
        if (ssd_en && (r_state == ST_LIT) && !(r_act_sup && !r_act_dp)) begin
            w_an_nxt  = ~(4'b0001 << r_digit);
            w_seg_nxt = r_act_sup ? SEG_BLANK : w_seg_dec;
            w_dpn_nxt = ~r_act_dp;
        end
    end

    always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
        if (!ssd_rst_n) begin
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_act_nib    <= 4'h0;
            r_act_dp     <= 1'b0;
            r_act_sup    <= 1'b0;
            ssd_an       <= AN_OFF;
            ssd_seg      <= SEG_BLANK;
            ssd_dp_n     <= 1'b1;
            ssd_digit    <= 2'd0;
        end else begin
            if (ssd_load) begin
                r_shadow_val <= ssd_val;
                r_shadow_dp  <= ssd_dp;
            end
            if (ssd_en) begin
                r_cnt   <= w_cnt_nxt;
                r_digit <= w_digit_nxt;
                if (w_cap) begin
                    r_act_nib <= w_src_shift[3:0];
                    r_act_dp  <= w_src_dp[r_digit];
                    r_act_sup <= (LZ_SUPPRESS != 0) && lz_zero(w_src_val, r_digit);
                end
            end else begin
                r_cnt   <= '0;
                r_digit <= 2'd0;
            end
            ssd_an    <= w_an_nxt;
            ssd_seg   <= w_seg_nxt;
            ssd_dp_n  <= w_dpn_nxt;
            ssd_digit <= ssd_en ? r_digit : 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan
// Description : Self-checking bench for ssd_scan (PRESCALE=8, BLANK_CYC=2,
//               LZ_SUPPRESS=1). Expected per-cycle outputs are queued when
//               stimulus is set up and popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic [1:0] dig;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    ssd_scan #(
        .PRESCALE    (8),
        .BLANK_CYC   (2),
        .LZ_SUPPRESS (1)
    ) dut (
        .ssd_clk   (clk),
        .ssd_rst_n (rst_n),
        .ssd_en    (en),
        .ssd_load  (load),
        .ssd_val   (val),
        .ssd_dp    (dp),
        .ssd_an    (an),
        .ssd_seg   (seg),
        .ssd_dp_n  (dp_n),
        .ssd_digit (digit)
    );

    function automatic obs_t dark(input logic [1:0] d);
        obs_t o;
        o.an = 4'b1111; o.seg = 7'b1111111; o.dp_n = 1'b1; o.dig = d;
        return o;
    endfunction

    // Expected lit-phase outputs for digit i of value v with dp bits d.
    function automatic obs_t lit_of(input logic [1:0] i, input logic [15:0] v, input logic [3:0] d);
        obs_t        o;
        logic [15:0] hi;
        logic [3:0]  nib;
        logic        sup;
        hi  = v >> (4 * i);
        nib = hi[3:0];
        sup = (i != 2'd0) && (hi == 16'h0000);
        if (sup && !d[i]) begin
            o = dark(i);
        end else begin
            o.an   = ~(4'b0001 << i);
            o.seg  = sup ? 7'b1111111 : hex_tab[nib];
            o.dp_n = ~d[i];
            o.dig  = i;
        end
        return o;
    endfunction

    task automatic push_slot(input logic [1:0] i, input logic [15:0] v, input logic [3:0] d);
        repeat (2) sb.push_back(dark(i));
        repeat (6) sb.push_back(lit_of(i, v, d));
    endtask

    // Stop the scan, load a value and re-enable on the following negedge so
    // the next posedge is the first cycle of digit0's blank phase.
    task automatic restart(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        en = 1'b0; load = 1'b1; val = v; dp = d;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        int   cyc;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; val = 16'h0; dp = 4'h0;
        #2;
        load = 1'b1; val = 16'hFFFF; dp = 4'hF; en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an: got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        n_cmp++; if (dp_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp_n: got %b want 1", dp_n); end
        n_cmp++; if (digit !== 2'd0) begin n_bad++; $display("FAIL reset_digit: got %0d want 0", digit); end
        // Loads during reset must not reach the shadow: value 0 shows.
        rst_n = 1'b1; load = 1'b0; en = 1'b1;
        push_slot(2'd0, 16'h0000, 4'h0);
        push_slot(2'd1, 16'h0000, 4'h0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); @(negedge clk); cyc++;
            exp = sb.pop_front();
            got = {an, seg, dp_n, digit};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_scan cyc %0d: got an=%b seg=%b dp_n=%b dig=%0d want an=%b seg=%b dp_n=%b dig=%0d",
                         cyc, got.an, got.seg, got.dp_n, got.dig, exp.an, exp.seg, exp.dp_n, exp.dig);
            end
        end
    endtask

    task automatic test_async_reset();
        restart(16'h1234, 4'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL async_pre_an: got %b want 1110", an); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL async_an: got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL async_seg: got %b want 1111111", seg); end
        n_cmp++; if (dp_n !== 1'b1) begin n_bad++; $display("FAIL async_dp_n: got %b want 1", dp_n); end
        n_cmp++; if (digit !== 2'd0) begin n_bad++; $display("FAIL async_digit: got %0d want 0", digit); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_scan();
        obs_t got, exp;
        int   cyc;
        restart(16'h1234, 4'h0);
        repeat (2) for (int i = 0; i < 4; i++) push_slot(i[1:0], 16'h1234, 4'h0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); @(negedge clk); cyc++;
            exp = sb.pop_front();
            got = {an, seg, dp_n, digit};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL scan cyc %0d: got an=%b seg=%b dp_n=%b dig=%0d want an=%b seg=%b dp_n=%b dig=%0d",
                         cyc, got.an, got.seg, got.dp_n, got.dig, exp.an, exp.seg, exp.dp_n, exp.dig);
            end
        end
    endtask

    task automatic test_lz();
        obs_t        got, exp;
        int          cyc;
        logic [15:0] vals [3] = '{16'h0007, 16'h0000, 16'h0070};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0100};
        for (int t = 0; t < 3; t++) begin
            restart(vals[t], dps[t]);
            for (int i = 0; i < 4; i++) push_slot(i[1:0], vals[t], dps[t]);
            cyc = 0;
            while (sb.size() > 0) begin
                @(posedge clk); @(negedge clk); cyc++;
                exp = sb.pop_front();
                got = {an, seg, dp_n, digit};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL lz val=%h cyc %0d: got an=%b seg=%b dp_n=%b dig=%0d want an=%b seg=%b dp_n=%b dig=%0d",
                             vals[t], cyc, got.an, got.seg, got.dp_n, got.dig, exp.an, exp.seg, exp.dp_n, exp.dig);
                end
            end
        end
    endtask

    task automatic test_midslot_load();
        obs_t got, exp;
        int   cyc;
        restart(16'h1234, 4'h0);
        push_slot(2'd0, 16'h1234, 4'h0);
        push_slot(2'd1, 16'h1234, 4'h0);   // mid-slot load must not disturb this digit
        push_slot(2'd2, 16'hABCD, 4'h0);
        push_slot(2'd3, 16'hABCD, 4'h0);
        push_slot(2'd0, 16'h5678, 4'b0001); // load on the capture edge is bypassed
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); @(negedge clk); cyc++;
            exp = sb.pop_front();
            got = {an, seg, dp_n, digit};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL midslot cyc %0d: got an=%b seg=%b dp_n=%b dig=%0d want an=%b seg=%b dp_n=%b dig=%0d",
                         cyc, got.an, got.seg, got.dp_n, got.dig, exp.an, exp.seg, exp.dp_n, exp.dig);
            end
            if (cyc == 12) begin load = 1'b1; val = 16'hABCD; end
            if (cyc == 13) load = 1'b0;
            if (cyc == 33) begin load = 1'b1; val = 16'h5678; dp = 4'b0001; end
            if (cyc == 34) load = 1'b0;
        end
    endtask

    task automatic test_enable();
        obs_t got, exp;
        int   cyc;
        restart(16'h1234, 4'h0);
        repeat (2) sb.push_back(dark(2'd0));
        repeat (2) sb.push_back(lit_of(2'd0, 16'h1234, 4'h0));
        sb.push_back(dark(2'd0));
        push_slot(2'd0, 16'h1234, 4'h0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk); @(negedge clk); cyc++;
            exp = sb.pop_front();
            got = {an, seg, dp_n, digit};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL enable cyc %0d: got an=%b seg=%b dp_n=%b dig=%0d want an=%b seg=%b dp_n=%b dig=%0d",
                         cyc, got.an, got.seg, got.dp_n, got.dig, exp.an, exp.seg, exp.dp_n, exp.dig);
            end
            if (cyc == 4) en = 1'b0;
            if (cyc == 5) en = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_scan();
        test_lz();
        test_midslot_load();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
